amm_transaction_ctrl: RTL and testbench
=======================================

AMM_TRANSACTION_CTRL -- requirements
Module: amm_transaction_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_AMM_W, default 512, Avalon-MM data width.
REQ-002 The block SHALL have parameter ADDR_W, default 31, Avalon-MM word address width.
REQ-003 The block SHALL have parameter BURST_W, default 11, burstcount width.
REQ-004 The block SHALL have parameter TIMEOUT_CYC, default 1024, read-wait timeout in cycles.
REQ-005 The block SHALL have ports: clk_i in 1 clock; rst_i in 1 asynchronous active-low reset; one clock domain only.
REQ-006 The block SHALL have ports: cmd_valid_i in 1; cmd_ready_o out 1; cmd_op_i in 2 (00 write, 01 read, 10 write-then-read); cmd_addr_i in ADDR_W; cmd_be_i in DATA_AMM_W/8; cmd_burst_i in BURST_W.
REQ-007 The block SHALL have ports: wr_data_i in DATA_AMM_W; wr_data_req_o out 1, one pulse per accepted write beat.
REQ-008 The block SHALL have ports: amm_address_o out ADDR_W; amm_write_o out 1; amm_read_o out 1; amm_writedata_o out DATA_AMM_W; amm_byteenable_o out DATA_AMM_W/8; amm_burstcount_o out BURST_W; amm_waitrequest_i in 1; amm_readdata_i in DATA_AMM_W; amm_readdatavalid_i in 1.
REQ-009 The block SHALL have ports: rd_data_o out DATA_AMM_W; rd_addr_o out ADDR_W; rd_data_valid_o out 1; abort_i in 1; busy_o out 1; err_timeout_o out 1; wr_trans_cnt_o out 32; rd_trans_cnt_o out 32.

Function
REQ-010 The FSM SHALL have states IDLE, WRITE, READ_REQ, READ_WAIT.
REQ-011 cmd_ready_o SHALL be 1 only in IDLE; a command SHALL be accepted on cmd_valid_i && cmd_ready_o, latching addr, be, op and burst; burst 0 SHALL be treated as 1.
REQ-012 On acceptance the FSM SHALL go to WRITE for ops 00/10 and to READ_REQ for op 01.
REQ-013 In WRITE, amm_write_o SHALL be 1 while beats remain; address and burstcount SHALL be held constant for the whole burst; a beat SHALL be accepted when amm_write_o && !amm_waitrequest_i.
REQ-014 amm_writedata_o SHALL equal wr_data_i combinationally; wr_data_req_o SHALL equal beat-accept; wr_data_i SHALL advance the cycle after.
REQ-015 amm_byteenable_o SHALL equal the latched be on beat 0 and all-ones on beats 1..N-1; in reads it SHALL be all-ones.
REQ-016 After the last write beat, the FSM SHALL go to READ_REQ for op 10 and to IDLE otherwise; wr_trans_cnt_o SHALL increment by 1.
REQ-017 In READ_REQ, amm_read_o SHALL be 1 until !amm_waitrequest_i, then the FSM SHALL go to READ_WAIT; amm_read_o SHALL be a single-cycle command per burst.
REQ-018 In READ_WAIT, each amm_readdatavalid_i SHALL register rd_data_o, set rd_data_valid_o one cycle later, and set rd_addr_o = burst base + beat index (mod 2^ADDR_W).
REQ-019 After N valid beats the FSM SHALL go to IDLE and rd_trans_cnt_o SHALL increment by 1.
REQ-020 Both counters SHALL saturate at 0xFFFF_FFFF.
REQ-021 A timeout counter SHALL reset on READ_WAIT entry and on each readdatavalid; reaching TIMEOUT_CYC SHALL set err_timeout_o (sticky until reset) and force IDLE without incrementing rd_trans_cnt_o.
REQ-022 amm_readdatavalid_i outside READ_WAIT SHALL be ignored.
REQ-023 abort_i SHALL force IDLE at the next cycle where no request is stalled; amm_write_o/amm_read_o SHALL NOT drop while amm_waitrequest_i=1.
REQ-024 busy_o SHALL be 1 in every state except IDLE.

Reset
REQ-025 Asserted rst_i SHALL force IDLE, all outputs 0 and cmd_ready_o 0, with cmd_ready_o going to 1 on the first clock after release, including mid-burst.

Structure
REQ-026 The op encoding enum and the state enum SHALL live in shared package mem_checker_pkg.
REQ-027 The block SHALL be a single module with no sub-modules.

Verification
REQ-028 The bench SHALL drive op=00, addr=0x100, burst=4, no waitrequest, and check 4 write beats, 4 wr_data_req_o pulses, be on beat 0 only, and wr_trans_cnt_o=1.
REQ-029 The bench SHALL drive op=10, burst=2, waitrequest high 3 cycles on beat 1, and check that write/address hold, a read follows, and 2 rd_data_valid_o with rd_addr_o 0x100, 0x101.
REQ-030 The bench SHALL drive op=01 with no readdatavalid for TIMEOUT_CYC cycles, and check that err_timeout_o=1, the FSM is in IDLE and rd_trans_cnt_o is unchanged.
REQ-031 The bench SHALL drive burst=0 and check that exactly 1 beat is issued.
REQ-032 The bench SHALL assert abort_i during a stalled write, and check that amm_write_o holds until waitrequest clears, then IDLE.
REQ-033 The bench SHALL assert rst_i mid-burst and check that all outputs are 0 and the next command executes normally.

Source files
------------

// File: rtl/mem_checker_pkg.sv
// -----------------------------------------------------------------------------
// mem_checker_pkg
//   Shared types for the memory-checker Avalon-MM transaction controller:
//   the command op encoding, the controller state encoding and a saturating
//   32-bit increment used by the transaction counters.
// -----------------------------------------------------------------------------
package mem_checker_pkg;

  // Command opcodes as presented on cmd_op_i.
  typedef enum logic [1:0] {
    OP_WRITE = 2'b00,
    OP_READ  = 2'b01,
    OP_WR_RD = 2'b10,
    OP_RSVD  = 2'b11
  } op_e;

  // Controller states.
  typedef enum logic [1:0] {
    ST_IDLE      = 2'b00,
    ST_WRITE     = 2'b01,
    ST_READ_REQ  = 2'b10,
    ST_READ_WAIT = 2'b11
  } state_e;

  localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    logic [31:0] r;
    if (v == CNT_MAX) begin
      r = v;
    end else begin
      r = v + 32'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/amm_transaction_ctrl.sv
// -----------------------------------------------------------------------------
// amm_transaction_ctrl
//   Turns single commands (write burst, read burst, write-then-read) into
//   Avalon-MM master bursts.
//
//   Ports
//     clk_i, rst_i            clock, asynchronous active-low reset
//     cmd_*                   command handshake (valid/ready) and fields
//     wr_data_i/wr_data_req_o write data source; one request pulse per beat
//     amm_*                   Avalon-MM master
//     rd_data_o/rd_addr_o/
//     rd_data_valid_o         registered read beats with their word address
//     abort_i                 return to IDLE once no request is stalled
//     busy_o, err_timeout_o   status; timeout error is sticky until reset
//     wr/rd_trans_cnt_o       saturating completed-transaction counters
// -----------------------------------------------------------------------------
module amm_transaction_ctrl
  import mem_checker_pkg::*;
#(
  parameter int DATA_AMM_W  = 512,
  parameter int ADDR_W      = 31,
  parameter int BURST_W     = 11,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    cmd_valid_i,
  output logic                    cmd_ready_o,
  input  logic [1:0]              cmd_op_i,
  input  logic [ADDR_W-1:0]       cmd_addr_i,
  input  logic [DATA_AMM_W/8-1:0] cmd_be_i,
  input  logic [BURST_W-1:0]      cmd_burst_i,
  input  logic [DATA_AMM_W-1:0]   wr_data_i,
  output logic                    wr_data_req_o,
  output logic [ADDR_W-1:0]       amm_address_o,
  output logic                    amm_write_o,
  output logic                    amm_read_o,
  output logic [DATA_AMM_W-1:0]   amm_writedata_o,
  output logic [DATA_AMM_W/8-1:0] amm_byteenable_o,
  output logic [BURST_W-1:0]      amm_burstcount_o,
  input  logic                    amm_waitrequest_i,
  input  logic [DATA_AMM_W-1:0]   amm_readdata_i,
  input  logic                    amm_readdatavalid_i,
  output logic [DATA_AMM_W-1:0]   rd_data_o,
  output logic [ADDR_W-1:0]       rd_addr_o,
  output logic                    rd_data_valid_o,
  input  logic                    abort_i,
  output logic                    busy_o,
  output logic                    err_timeout_o,
  output logic [31:0]             wr_trans_cnt_o,
  output logic [31:0]             rd_trans_cnt_o
);

  localparam int BE_W  = DATA_AMM_W / 8;
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

  state_e                  state_q, state_d;
  logic                    alive_q;       // low in reset and for one clock after
  op_e                     op_q;
  logic [ADDR_W-1:0]       addr_q;
  logic [BE_W-1:0]         be_q;
  logic [BURST_W-1:0]      burst_q;
  logic [BURST_W-1:0]      beat_q;        // write beats, then read beats
  logic                    abort_pend_q;
  logic [TMO_W-1:0]        tmo_q;
  logic                    err_q;
  logic [DATA_AMM_W-1:0]   rd_data_q;
  logic [ADDR_W-1:0]       rd_addr_q;
  logic                    rd_valid_q;
  logic [31:0]             wr_cnt_q;
  logic [31:0]             rd_cnt_q;

  logic                    cmd_accept_s;
  logic                    wr_beat_s;
  logic                    rd_beat_s;
  logic                    last_beat_s;
  logic                    abort_s;
  logic                    tmo_hit_s;
  logic                    wr_done_s;
  logic                    rd_done_s;

  logic                    amm_write_s;
  logic                    amm_read_s;
  logic [ADDR_W-1:0]       amm_address_s;
  logic [BURST_W-1:0]      amm_burst_s;
  logic [BE_W-1:0]         amm_be_s;
  logic [DATA_AMM_W-1:0]   amm_wdata_s;

  assign cmd_accept_s = cmd_valid_i && cmd_ready_o;
  assign wr_beat_s    = (state_q == ST_WRITE) && !amm_waitrequest_i;
  // Data returning outside READ_WAIT is dropped here.
  assign rd_beat_s    = (state_q == ST_READ_WAIT) && amm_readdatavalid_i;
  assign last_beat_s  = (beat_q == (burst_q - BURST_W'(1)));
  assign abort_s      = abort_i || abort_pend_q;
  assign tmo_hit_s    = (state_q == ST_READ_WAIT) && !amm_readdatavalid_i &&
                        (tmo_q == TMO_W'(TIMEOUT_CYC - 1));
  assign wr_done_s    = wr_beat_s && last_beat_s;
  assign rd_done_s    = rd_beat_s && last_beat_s;

  // State register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. A stalled request (waitrequest high) always holds the
  // state so write/read never drop mid-handshake, even under abort.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_accept_s) begin
          state_d = (cmd_op_i == OP_READ) ? ST_READ_REQ : ST_WRITE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WRITE: begin
        if (wr_done_s) begin
          state_d = ((op_q == OP_WR_RD) && !abort_s) ? ST_READ_REQ : ST_IDLE;
        end else if (wr_beat_s && abort_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WRITE;
        end
      end
      ST_READ_REQ: begin
        if (!amm_waitrequest_i) begin
          state_d = abort_s ? ST_IDLE : ST_READ_WAIT;
        end else begin
          state_d = ST_READ_REQ;
        end
      end
      ST_READ_WAIT: begin
        if (rd_done_s || abort_s || tmo_hit_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_READ_WAIT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Bus outputs decoded from the registered state; address and burstcount
  // come from the latched command so they stay constant across the burst.
  always_comb begin
    amm_write_s   = 1'b0;
    amm_read_s    = 1'b0;
    amm_address_s = {ADDR_W{1'b0}};
    amm_burst_s   = {BURST_W{1'b0}};
    amm_be_s      = {BE_W{1'b0}};
    amm_wdata_s   = {DATA_AMM_W{1'b0}};
    case (state_q)
      ST_WRITE: begin
        amm_write_s   = 1'b1;
        amm_address_s = addr_q;
        amm_burst_s   = burst_q;
        amm_be_s      = (beat_q == {BURST_W{1'b0}}) ? be_q : {BE_W{1'b1}};
        amm_wdata_s   = wr_data_i;
      end
      ST_READ_REQ: begin
        amm_read_s    = 1'b1;
        amm_address_s = addr_q;
        amm_burst_s   = burst_q;
        amm_be_s      = {BE_W{1'b1}};
      end
      ST_IDLE, ST_READ_WAIT: begin
        amm_write_s = 1'b0;
      end
      default: begin
        amm_write_s = 1'b0;
      end
    endcase
  end

  // Command latch and beat counter.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      alive_q <= 1'b0;
      op_q    <= OP_WRITE;
      addr_q  <= {ADDR_W{1'b0}};
      be_q    <= {BE_W{1'b0}};
      burst_q <= {BURST_W{1'b0}};
      beat_q  <= {BURST_W{1'b0}};
    end else begin
      alive_q <= 1'b1;
      if (cmd_accept_s) begin
        op_q    <= op_e'(cmd_op_i);
        addr_q  <= cmd_addr_i;
        be_q    <= cmd_be_i;
        burst_q <= (cmd_burst_i == {BURST_W{1'b0}}) ? BURST_W'(1) : cmd_burst_i;
      end
      if (cmd_accept_s || (state_q == ST_READ_REQ)) begin
        beat_q <= {BURST_W{1'b0}};
      end else if (wr_beat_s || rd_beat_s) begin
        beat_q <= beat_q + BURST_W'(1);
      end
    end
  end

  // Abort is remembered until the FSM can actually leave; cleared in IDLE
  // so an abort seen while idle never cancels the next command.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      abort_pend_q <= 1'b0;
    end else if ((state_q == ST_IDLE) || (state_d == ST_IDLE)) begin
      abort_pend_q <= 1'b0;
    end else if (abort_i) begin
      abort_pend_q <= 1'b1;
    end
  end

  // Read-wait timeout: counts idle READ_WAIT cycles, restarts on each beat.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      tmo_q <= {TMO_W{1'b0}};
      err_q <= 1'b0;
    end else begin
      if ((state_q != ST_READ_WAIT) || amm_readdatavalid_i) begin
        tmo_q <= {TMO_W{1'b0}};
      end else if (!tmo_hit_s) begin
        tmo_q <= tmo_q + TMO_W'(1);
      end
      if (tmo_hit_s) begin
        err_q <= 1'b1;
      end
    end
  end

  // Read data capture; address wraps naturally at 2^ADDR_W.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rd_data_q  <= {DATA_AMM_W{1'b0}};
      rd_addr_q  <= {ADDR_W{1'b0}};
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_beat_s;
      if (rd_beat_s) begin
        rd_data_q <= amm_readdata_i;
        rd_addr_q <= addr_q + ADDR_W'(beat_q);
      end
    end
  end

  // Completed-transaction counters.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_cnt_q <= 32'd0;
      rd_cnt_q <= 32'd0;
    end else begin
      if (wr_done_s) begin
        wr_cnt_q <= sat_inc32(wr_cnt_q);
      end
      if (rd_done_s) begin
        rd_cnt_q <= sat_inc32(rd_cnt_q);
      end
    end
  end

  assign cmd_ready_o      = alive_q && (state_q == ST_IDLE);
  assign busy_o           = (state_q != ST_IDLE);
  assign wr_data_req_o    = wr_beat_s;
  assign amm_write_o      = amm_write_s;
  assign amm_read_o       = amm_read_s;
  assign amm_address_o    = amm_address_s;
  assign amm_burstcount_o = amm_burst_s;
  assign amm_byteenable_o = amm_be_s;
  assign amm_writedata_o  = amm_wdata_s;
  assign rd_data_o        = rd_data_q;
  assign rd_addr_o        = rd_addr_q;
  assign rd_data_valid_o  = rd_valid_q;
  assign err_timeout_o    = err_q;
  assign wr_trans_cnt_o   = wr_cnt_q;
  assign rd_trans_cnt_o   = rd_cnt_q;

endmodule

// File: tb/tb_amm_transaction_ctrl.sv
// -----------------------------------------------------------------------------
// tb_amm_transaction_ctrl
//   Directed scenarios for amm_transaction_ctrl with hand-computed
//   expectations. Inputs change 1 time unit after the rising edge, outputs
//   are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_amm_transaction_ctrl;

  localparam int DW   = 32;
  localparam int AW   = 31;
  localparam int BW   = 11;
  localparam int TMO  = 16;
  localparam int BEW  = DW / 8;

  logic           clk_i = 1'b0;
  logic           rst_i;
  logic           cmd_valid_i;
  logic           cmd_ready_o;
  logic [1:0]     cmd_op_i;
  logic [AW-1:0]  cmd_addr_i;
  logic [BEW-1:0] cmd_be_i;
  logic [BW-1:0]  cmd_burst_i;
  logic [DW-1:0]  wr_data_i;
  logic           wr_data_req_o;
  logic [AW-1:0]  amm_address_o;
  logic           amm_write_o;
  logic           amm_read_o;
  logic [DW-1:0]  amm_writedata_o;
  logic [BEW-1:0] amm_byteenable_o;
  logic [BW-1:0]  amm_burstcount_o;
  logic           amm_waitrequest_i;
  logic [DW-1:0]  amm_readdata_i;
  logic           amm_readdatavalid_i;
  logic [DW-1:0]  rd_data_o;
  logic [AW-1:0]  rd_addr_o;
  logic           rd_data_valid_o;
  logic           abort_i;
  logic           busy_o;
  logic           err_timeout_o;
  logic [31:0]    wr_trans_cnt_o;
  logic [31:0]    rd_trans_cnt_o;

  int errors = 0;
  int checks = 0;

  amm_transaction_ctrl #(
    .DATA_AMM_W (DW),
    .ADDR_W     (AW),
    .BURST_W    (BW),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .clk_i              (clk_i),
    .rst_i              (rst_i),
    .cmd_valid_i        (cmd_valid_i),
    .cmd_ready_o        (cmd_ready_o),
    .cmd_op_i           (cmd_op_i),
    .cmd_addr_i         (cmd_addr_i),
    .cmd_be_i           (cmd_be_i),
    .cmd_burst_i        (cmd_burst_i),
    .wr_data_i          (wr_data_i),
    .wr_data_req_o      (wr_data_req_o),
    .amm_address_o      (amm_address_o),
    .amm_write_o        (amm_write_o),
    .amm_read_o         (amm_read_o),
    .amm_writedata_o    (amm_writedata_o),
    .amm_byteenable_o   (amm_byteenable_o),
    .amm_burstcount_o   (amm_burstcount_o),
    .amm_waitrequest_i  (amm_waitrequest_i),
    .amm_readdata_i     (amm_readdata_i),
    .amm_readdatavalid_i(amm_readdatavalid_i),
    .rd_data_o          (rd_data_o),
    .rd_addr_o          (rd_addr_o),
    .rd_data_valid_o    (rd_data_valid_o),
    .abort_i            (abort_i),
    .busy_o             (busy_o),
    .err_timeout_o      (err_timeout_o),
    .wr_trans_cnt_o     (wr_trans_cnt_o),
    .rd_trans_cnt_o     (rd_trans_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // Drives one command for one cycle; called 1 unit after a rising edge.
  task automatic issue_cmd(input logic [1:0] op, input logic [AW-1:0] addr,
                           input logic [BEW-1:0] be, input logic [BW-1:0] burst);
    cmd_valid_i = 1'b1;
    cmd_op_i    = op;
    cmd_addr_i  = addr;
    cmd_be_i    = be;
    cmd_burst_i = burst;
    @(posedge clk_i); #1;
    cmd_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    logic [6:0] flags;
    rst_i = 1'b0;
    cmd_valid_i = 1'b0; cmd_op_i = 2'b00; cmd_addr_i = '0; cmd_be_i = '0;
    cmd_burst_i = '0; wr_data_i = 32'h1234_5678; amm_waitrequest_i = 1'b0;
    amm_readdata_i = '0; amm_readdatavalid_i = 1'b0; abort_i = 1'b0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    flags = {cmd_ready_o, wr_data_req_o, amm_write_o, amm_read_o,
             rd_data_valid_o, busy_o, err_timeout_o};
    checks++;
    if (flags !== 7'b0) begin
      errors++; $display("FAIL reset_flags: got %b expected 0000000", flags);
    end
    checks++;
    if ((amm_address_o | amm_burstcount_o | amm_byteenable_o | amm_writedata_o) !== '0) begin
      errors++; $display("FAIL reset_bus: addr %h bc %h be %h wd %h expected all 0",
                         amm_address_o, amm_burstcount_o, amm_byteenable_o, amm_writedata_o);
    end
    checks++;
    if (wr_trans_cnt_o !== 32'd0 || rd_trans_cnt_o !== 32'd0) begin
      errors++; $display("FAIL reset_cnt: wr %0d rd %0d expected 0 0", wr_trans_cnt_o, rd_trans_cnt_o);
    end
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    @(negedge clk_i);
    checks++;
    if (cmd_ready_o !== 1'b0) begin
      errors++; $display("FAIL reset_ready_early: got %b expected 0", cmd_ready_o);
    end
    @(posedge clk_i);
    @(negedge clk_i);
    checks++;
    if (cmd_ready_o !== 1'b1 || busy_o !== 1'b0) begin
      errors++; $display("FAIL reset_ready: ready %b busy %b expected 1 0", cmd_ready_o, busy_o);
    end
    @(posedge clk_i); #1;
  endtask

  task automatic test_write_burst();
    int wr_cyc = 0;
    int req_cnt = 0;
    int beat = 0;
    logic [BEW-1:0] exp_be;
    amm_waitrequest_i = 1'b0;
    wr_data_i = 32'hA5A5_0000;
    issue_cmd(2'b00, 31'h100, 4'b0011, 11'd4);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk_i);
      if (amm_write_o === 1'b1) begin
        wr_cyc++;
        exp_be = (beat == 0) ? 4'b0011 : 4'b1111;
        checks++;
        if (amm_address_o !== 31'h100 || amm_burstcount_o !== 11'd4) begin
          errors++; $display("FAIL wr_addr_bc: addr %h bc %0d expected 100 4", amm_address_o, amm_burstcount_o);
        end
        checks++;
        if (amm_byteenable_o !== exp_be) begin
          errors++; $display("FAIL wr_be beat %0d: got %b expected %b", beat, amm_byteenable_o, exp_be);
        end
        checks++;
        if (amm_writedata_o !== (32'hA5A5_0000 | 32'(beat))) begin
          errors++; $display("FAIL wr_data beat %0d: got %h expected %h", beat, amm_writedata_o,
                             32'hA5A5_0000 | 32'(beat));
        end
      end
      if (wr_data_req_o === 1'b1) begin
        req_cnt++;
        beat++;
      end
      @(posedge clk_i); #1;
      wr_data_i = 32'hA5A5_0000 | 32'(beat);
    end
    checks++;
    if (wr_cyc != 4) begin
      errors++; $display("FAIL wr_beats: got %0d expected 4", wr_cyc);
    end
    checks++;
    if (req_cnt != 4) begin
      errors++; $display("FAIL wr_req_pulses: got %0d expected 4", req_cnt);
    end
    checks++;
    if (wr_trans_cnt_o !== 32'd1 || busy_o !== 1'b0) begin
      errors++; $display("FAIL wr_cnt: cnt %0d busy %b expected 1 0", wr_trans_cnt_o, busy_o);
    end
  endtask

  task automatic test_write_read();
    int wbeat = 0;
    int stall = 0;
    int stall_seen = 0;
    int rd_cmd_cyc = 0;
    int resp_wait = -1;
    int resp_beat = 0;
    int rv_cnt = 0;
    amm_waitrequest_i = 1'b0;
    wr_data_i = 32'hB000_0000;
    issue_cmd(2'b10, 31'h100, 4'b0101, 11'd2);
    for (int c = 0; c < 30; c++) begin
      @(negedge clk_i);
      if (amm_write_o === 1'b1 && amm_waitrequest_i === 1'b1) begin
        stall_seen++;
        checks++;
        if (amm_address_o !== 31'h100 || amm_burstcount_o !== 11'd2 || wr_data_req_o !== 1'b0) begin
          errors++; $display("FAIL wr_hold: addr %h bc %0d req %b expected 100 2 0",
                             amm_address_o, amm_burstcount_o, wr_data_req_o);
        end
      end
      if (wr_data_req_o === 1'b1) wbeat++;
      if (amm_read_o === 1'b1) begin
        rd_cmd_cyc++;
        checks++;
        if (wbeat != 2 || amm_address_o !== 31'h100 || amm_burstcount_o !== 11'd2 ||
            amm_byteenable_o !== 4'hF) begin
          errors++; $display("FAIL rd_cmd: wbeats %0d addr %h bc %0d be %b expected 2 100 2 1111",
                             wbeat, amm_address_o, amm_burstcount_o, amm_byteenable_o);
        end
        if (amm_waitrequest_i === 1'b0) resp_wait = 2;
      end
      if (rd_data_valid_o === 1'b1) begin
        checks++;
        if (rd_addr_o !== (31'h100 + 31'(rv_cnt)) || rd_data_o !== (32'hD00D_0000 | 32'(rv_cnt))) begin
          errors++; $display("FAIL rd_beat %0d: addr %h data %h expected %h %h", rv_cnt, rd_addr_o,
                             rd_data_o, 31'h100 + 31'(rv_cnt), 32'hD00D_0000 | 32'(rv_cnt));
        end
        rv_cnt++;
      end
      @(posedge clk_i); #1;
      wr_data_i = 32'hB000_0000 | 32'(wbeat);
      amm_readdatavalid_i = 1'b0;
      if (resp_wait > 0) begin
        resp_wait--;
      end else if (resp_wait == 0 && resp_beat < 2) begin
        amm_readdatavalid_i = 1'b1;
        amm_readdata_i = 32'hD00D_0000 | 32'(resp_beat);
        resp_beat++;
      end
      if (wbeat == 1 && stall < 3) begin
        amm_waitrequest_i = 1'b1;
        stall++;
      end else begin
        amm_waitrequest_i = 1'b0;
      end
    end
    checks++;
    if (stall_seen != 3) begin
      errors++; $display("FAIL wr_stall_cycles: got %0d expected 3", stall_seen);
    end
    checks++;
    if (rd_cmd_cyc != 1) begin
      errors++; $display("FAIL rd_cmd_cycles: got %0d expected 1", rd_cmd_cyc);
    end
    checks++;
    if (rv_cnt != 2) begin
      errors++; $display("FAIL rd_valid_count: got %0d expected 2", rv_cnt);
    end
    checks++;
    if (wr_trans_cnt_o !== 32'd2 || rd_trans_cnt_o !== 32'd1 || busy_o !== 1'b0) begin
      errors++; $display("FAIL wrrd_cnt: wr %0d rd %0d busy %b expected 2 1 0",
                         wr_trans_cnt_o, rd_trans_cnt_o, busy_o);
    end
  endtask

  task automatic test_timeout();
    amm_waitrequest_i = 1'b0;
    amm_readdatavalid_i = 1'b0;
    issue_cmd(2'b01, 31'h200, 4'hF, 11'd1);
    // One edge into READ_WAIT, then TIMEOUT_CYC waiting cycles.
    repeat (TMO) @(posedge clk_i);
    @(negedge clk_i);
    checks++;
    if (err_timeout_o !== 1'b0 || busy_o !== 1'b1) begin
      errors++; $display("FAIL tmo_early: err %b busy %b expected 0 1", err_timeout_o, busy_o);
    end
    @(posedge clk_i);
    @(negedge clk_i);
    checks++;
    if (err_timeout_o !== 1'b1) begin
      errors++; $display("FAIL tmo_err: got %b expected 1", err_timeout_o);
    end
    checks++;
    if (busy_o !== 1'b0 || cmd_ready_o !== 1'b1) begin
      errors++; $display("FAIL tmo_idle: busy %b ready %b expected 0 1", busy_o, cmd_ready_o);
    end
    checks++;
    if (rd_trans_cnt_o !== 32'd1) begin
      errors++; $display("FAIL tmo_rd_cnt: got %0d expected 1", rd_trans_cnt_o);
    end
    @(posedge clk_i); #1;
  endtask

  task automatic test_burst_zero();
    int wr_cyc = 0;
    int req_cnt = 0;
    // Stray read data while idle must be dropped.
    amm_readdatavalid_i = 1'b1;
    amm_readdata_i = 32'hDEAD_BEEF;
    @(posedge clk_i); #1;
    amm_readdatavalid_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if (rd_data_valid_o !== 1'b0) begin
      errors++; $display("FAIL idle_rdv_ignored: got %b expected 0", rd_data_valid_o);
    end
    @(posedge clk_i); #1;
    amm_waitrequest_i = 1'b0;
    wr_data_i = 32'h0000_0ABC;
    issue_cmd(2'b00, 31'h300, 4'b1000, 11'd0);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk_i);
      if (amm_write_o === 1'b1) begin
        wr_cyc++;
        checks++;
        if (amm_burstcount_o !== 11'd1 || amm_byteenable_o !== 4'b1000) begin
          errors++; $display("FAIL b0_bc_be: bc %0d be %b expected 1 1000", amm_burstcount_o, amm_byteenable_o);
        end
      end
      if (wr_data_req_o === 1'b1) req_cnt++;
      @(posedge clk_i); #1;
    end
    checks++;
    if (wr_cyc != 1 || req_cnt != 1) begin
      errors++; $display("FAIL b0_beats: writes %0d reqs %0d expected 1 1", wr_cyc, req_cnt);
    end
    checks++;
    if (wr_trans_cnt_o !== 32'd3) begin
      errors++; $display("FAIL b0_cnt: got %0d expected 3", wr_trans_cnt_o);
    end
  endtask

  task automatic test_abort();
    amm_waitrequest_i = 1'b1;
    wr_data_i = 32'h0000_0400;
    issue_cmd(2'b00, 31'h400, 4'hF, 11'd4);
    abort_i = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk_i);
      checks++;
      if (amm_write_o !== 1'b1 || amm_address_o !== 31'h400) begin
        errors++; $display("FAIL abort_hold %0d: write %b addr %h expected 1 400", c, amm_write_o, amm_address_o);
      end
      @(posedge clk_i); #1;
      abort_i = 1'b0;
    end
    amm_waitrequest_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if (amm_write_o !== 1'b1 || wr_data_req_o !== 1'b1) begin
      errors++; $display("FAIL abort_release: write %b req %b expected 1 1", amm_write_o, wr_data_req_o);
    end
    @(posedge clk_i); #1;
    @(negedge clk_i);
    checks++;
    if (amm_write_o !== 1'b0 || busy_o !== 1'b0 || cmd_ready_o !== 1'b1) begin
      errors++; $display("FAIL abort_idle: write %b busy %b ready %b expected 0 0 1",
                         amm_write_o, busy_o, cmd_ready_o);
    end
    checks++;
    if (wr_trans_cnt_o !== 32'd3) begin
      errors++; $display("FAIL abort_cnt: got %0d expected 3", wr_trans_cnt_o);
    end
    @(posedge clk_i); #1;
  endtask

  task automatic test_reset_mid_burst();
    logic [6:0] flags;
    int wr_cyc = 0;
    amm_waitrequest_i = 1'b0;
    wr_data_i = 32'hC0DE_0001;
    issue_cmd(2'b00, 31'h500, 4'hF, 11'd8);
    @(negedge clk_i);
    checks++;
    if (amm_write_o !== 1'b1) begin
      errors++; $display("FAIL rst_pre_write: got %b expected 1", amm_write_o);
    end
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    flags = {cmd_ready_o, wr_data_req_o, amm_write_o, amm_read_o,
             rd_data_valid_o, busy_o, err_timeout_o};
    checks++;
    if (flags !== 7'b0) begin
      errors++; $display("FAIL rst_mid_flags: got %b expected 0000000", flags);
    end
    checks++;
    if ((amm_address_o | amm_burstcount_o | amm_byteenable_o | amm_writedata_o |
         rd_addr_o | rd_data_o) !== '0) begin
      errors++; $display("FAIL rst_mid_bus: addr %h bc %h be %h wd %h expected all 0",
                         amm_address_o, amm_burstcount_o, amm_byteenable_o, amm_writedata_o);
    end
    checks++;
    if (wr_trans_cnt_o !== 32'd0 || rd_trans_cnt_o !== 32'd0) begin
      errors++; $display("FAIL rst_mid_cnt: wr %0d rd %0d expected 0 0", wr_trans_cnt_o, rd_trans_cnt_o);
    end
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    checks++;
    if (cmd_ready_o !== 1'b1) begin
      errors++; $display("FAIL rst_mid_ready: got %b expected 1", cmd_ready_o);
    end
    @(posedge clk_i); #1;
    issue_cmd(2'b00, 31'h600, 4'hF, 11'd2);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk_i);
      if (amm_write_o === 1'b1) begin
        wr_cyc++;
        checks++;
        if (amm_address_o !== 31'h600) begin
          errors++; $display("FAIL rst_next_addr: got %h expected 600", amm_address_o);
        end
      end
      @(posedge clk_i); #1;
    end
    checks++;
    if (wr_cyc != 2 || wr_trans_cnt_o !== 32'd1) begin
      errors++; $display("FAIL rst_next_cmd: beats %0d cnt %0d expected 2 1", wr_cyc, wr_trans_cnt_o);
    end
  endtask

  initial begin
    test_reset();
    test_write_burst();
    test_write_read();
    test_timeout();
    test_burst_zero();
    test_abort();
    test_reset_mid_burst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before end of tests");
    $fatal(1, "watchdog expired");
  end

endmodule
